// File: rtl/pipe_latch_ctrl.sv
// Sequencing controller for the F/D, D/X, X/M, M/W latches and the PC register.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_latch_ctrl #(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        md_start,
   input  logic        branch_taken,
   input  logic        ld_use_hazard,
   output logic        pc_en,
   output logic        fd_en,
   output logic        dx_en,
   output logic        xm_en,
   output logic        mw_en,
   output logic        fd_clr,
   output logic        dx_clr,
   output logic        xm_clr,
   output logic        mw_clr,
   output logic        md_busy,
   output logic        md_done
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [15:0] perf_stall_cnt,
   output logic [15:0] perf_flush_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] MD_BUSY = 2'd1;
   localparam logic [1:0] MD_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             branch_flush;

   always_comb begin
      pc_en        = 1'b1;
      fd_en        = 1'b1;
      dx_en        = 1'b1;
      xm_en        = 1'b1;
      mw_en        = 1'b1;
      fd_clr       = 1'b0;
      dx_clr       = 1'b0;
      xm_clr       = 1'b0;
      mw_clr       = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
      branch_flush = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;

      case (state_q)
         IDLE: begin
            if (md_start) begin
               pc_en   = 1'b0;
               fd_en   = 1'b0;
               dx_en   = 1'b0;
               xm_en   = 1'b0;
               mw_clr  = 1'b1;
               md_busy = 1'b1;
               state_d = MD_BUSY;
               cnt_d   = CNT_W'(MD_CYCLES - 1);
            end else if (branch_taken) begin
               // Branch beats load-use: the dependent instruction is flushed anyway.
               fd_clr       = 1'b1;
               dx_clr       = 1'b1;
               branch_flush = 1'b1;
            end else if (ld_use_hazard) begin
               pc_en  = 1'b0;
               fd_en  = 1'b0;
               dx_clr = 1'b1;
            end
         end
         MD_BUSY: begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            dx_en   = 1'b0;
            xm_en   = 1'b0;
            mw_clr  = 1'b1;
            md_busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = MD_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MD_DONE: begin
            md_done = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (reset) begin
         pc_en        = 1'b0;
         fd_en        = 1'b0;
         dx_en        = 1'b0;
         xm_en        = 1'b0;
         mw_en        = 1'b0;
         fd_clr       = 1'b1;
         dx_clr       = 1'b1;
         xm_clr       = 1'b1;
         mw_clr       = 1'b1;
         md_busy      = 1'b0;
         md_done      = 1'b0;
         branch_flush = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Reset already forces pc_en low, so the reset branch keeps it from counting.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!pc_en && perf_stall_cnt != 16'hFFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         end
         if (branch_flush && perf_flush_cnt != 16'hFFFF) begin
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_branch_flush;
   assign unused_branch_flush = branch_flush;
`endif

endmodule
